z2_autoconfig_ram: RTL and testbench

// Zorro II expansion-card slave: Amiga bus interface with AutoConfig and an on-chip RAM window.
// - Before configuration: answers the AutoConfig space at $E80000 while znCFGIN is low.
// - After base assignment: decodes a 2 MB window at that base and serves 16-bit reads/writes with byte strobes.
// - Sits between the Zorro edge connector pins and the card's memory.

---
 rtl/z2_autoconfig_ram_if.sv | 22 ++
 rtl/z2_autoconfig_ram.sv | 171 +++++++++++++++++
 tb/tb_z2_autoconfig_ram.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/z2_autoconfig_ram_if.sv
// Zorro II bus signals seen by an expansion card; the data bus stays a plain inout on the card.
interface z2_autoconfig_ram_if;
   logic        znAS;
   logic        znUDS;
   logic        znLDS;
   logic        zREAD;
   logic [23:0] zA;
   logic        zDOE;
   logic        znCFGIN;
   logic        znCFGOUT;
   logic        zSLAVEN;

   modport master (
      output znAS, znUDS, znLDS, zREAD, zA, zDOE, znCFGIN,
      input  znCFGOUT, zSLAVEN
   );

   modport slave (
      input  znAS, znUDS, znLDS, zREAD, zA, zDOE, znCFGIN,
      output znCFGOUT, zSLAVEN
   );
endinterface

// File: rtl/z2_autoconfig_ram.sv
// Zorro II slave: AutoConfig at $E80000, then a 2 MB on-chip RAM window at the assigned base.
// Optional Z2_SHUTUP_EN: a write to $4C configures the card with no window.
module z2_autoconfig_ram #(
   parameter logic [7:0]  PRODUCT_ID = 8'h01,
   parameter logic [15:0] MANUF_ID   = 16'h6D6E,
   parameter logic [31:0] SERIAL     = 32'h0,
   parameter logic [2:0]  SIZE_CODE  = 3'd6,
   parameter int          RAM_AW     = 10
) (
   input  logic               z_sample_clk,
   input  logic               reset_n,
   z2_autoconfig_ram_if.slave bus,
   inout  wire  [15:0]        zD
);
   localparam logic [7:0] ER_TYPE = {2'b11, 1'b0, 1'b0, 1'b0, SIZE_CODE};
   localparam logic [7:0] FLAGS   = 8'h00;

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [1:0] as_s, uds_s, lds_s, rd_s, doe_s;
   logic       as_prev;

   always_ff @(posedge z_sample_clk or negedge reset_n) begin
      if (!reset_n) begin
         as_s    <= 2'b11;
         uds_s   <= 2'b11;
         lds_s   <= 2'b11;
         rd_s    <= 2'b11;
         doe_s   <= 2'b00;
         as_prev <= 1'b1;
      end else begin
         as_s    <= {as_s[0],  bus.znAS};
         uds_s   <= {uds_s[0], bus.znUDS};
         lds_s   <= {lds_s[0], bus.znLDS};
         rd_s    <= {rd_s[0],  bus.zREAD};
         doe_s   <= {doe_s[0], bus.zDOE};
         as_prev <= as_s[1];
      end
   end

   wire as_fall = as_prev & ~as_s[1];

   state_t              state;
   logic                slave_n, cfgout_n, configured, is_cfg, wr_done, rd_valid;
   logic [7:0]          base;
   logic [7:1]          off_lat;
   logic [RAM_AW:1]     word_lat;
   logic [15:0]         d_lat;
   logic                window_en;

`ifdef Z2_SHUTUP_EN
   logic shutup;
   assign window_en = ~shutup;
`else
   assign window_en = 1'b1;
`endif

   wire cfg_hit = ~configured & ~bus.znCFGIN & (bus.zA[23:16] == 8'hE8);
   wire ram_hit = configured & window_en & (bus.zA[23:21] == base[7:5]);

   // One write per bus cycle, on the first clock a data strobe is seen.
   wire wr_fire = (state == ACTIVE) & ~as_s[1] & ~rd_s[1] & ~wr_done &
                  (~uds_s[1] | ~lds_s[1]);

   wire [7:0] cfg_off = {off_lat, 1'b0};

   always_ff @(posedge z_sample_clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         slave_n    <= 1'b1;
         cfgout_n   <= 1'b1;
         configured <= 1'b0;
         base       <= 8'h00;
         is_cfg     <= 1'b0;
         wr_done    <= 1'b0;
         rd_valid   <= 1'b0;
         off_lat    <= '0;
         word_lat   <= '0;
         d_lat      <= 16'h0000;
`ifdef Z2_SHUTUP_EN
         shutup     <= 1'b0;
`endif
      end else begin
         cfgout_n <= ~configured;
         case (state)
            IDLE: begin
               rd_valid <= 1'b0;
               if (as_fall) begin
                  off_lat  <= bus.zA[7:1];
                  word_lat <= bus.zA[RAM_AW:1];
                  d_lat    <= zD;
                  if (cfg_hit || ram_hit) begin
                     state   <= ACTIVE;
                     slave_n <= 1'b0;
                     is_cfg  <= cfg_hit;
                     wr_done <= 1'b0;
                  end
               end
            end
            ACTIVE: begin
               rd_valid <= 1'b1;
               if (as_s[1]) begin
                  state    <= IDLE;
                  slave_n  <= 1'b1;
                  rd_valid <= 1'b0;
               end else if (wr_fire) begin
                  wr_done <= 1'b1;
                  if (is_cfg && cfg_off == 8'h48) begin
                     base       <= d_lat[15:8];
                     configured <= 1'b1;
                  end
`ifdef Z2_SHUTUP_EN
                  if (is_cfg && cfg_off == 8'h4C) begin
                     shutup     <= 1'b1;
                     configured <= 1'b1;
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // AutoConfig nibble: er_Type is plain, everything else is stored inverted.
   logic [3:0] cfg_nib;
   always_comb begin
      cfg_nib = 4'hF;
      case (cfg_off)
         8'h00: cfg_nib = ER_TYPE[7:4];
         8'h02: cfg_nib = ER_TYPE[3:0];
         8'h04: cfg_nib = ~PRODUCT_ID[7:4];
         8'h06: cfg_nib = ~PRODUCT_ID[3:0];
         8'h08: cfg_nib = ~FLAGS[7:4];
         8'h0A: cfg_nib = ~FLAGS[3:0];
         8'h10: cfg_nib = ~MANUF_ID[15:12];
         8'h12: cfg_nib = ~MANUF_ID[11:8];
         8'h14: cfg_nib = ~MANUF_ID[7:4];
         8'h16: cfg_nib = ~MANUF_ID[3:0];
         8'h18: cfg_nib = ~SERIAL[31:28];
         8'h1A: cfg_nib = ~SERIAL[27:24];
         8'h1C: cfg_nib = ~SERIAL[23:20];
         8'h1E: cfg_nib = ~SERIAL[19:16];
         8'h20: cfg_nib = ~SERIAL[15:12];
         8'h22: cfg_nib = ~SERIAL[11:8];
         8'h24: cfg_nib = ~SERIAL[7:4];
         8'h26: cfg_nib = ~SERIAL[3:0];
         default: cfg_nib = 4'hF;
      endcase
   end

   logic [15:0] ram [2**RAM_AW];
   logic [15:0] rd_data;

   always_ff @(posedge z_sample_clk) begin
      if (wr_fire && !is_cfg) begin
         if (!uds_s[1]) ram[word_lat][15:8] <= d_lat[15:8];
         if (!lds_s[1]) ram[word_lat][7:0]  <= d_lat[7:0];
      end
      rd_data <= is_cfg ? {cfg_nib, 12'hFFF} : ram[word_lat];
   end

   // rd_valid holds the bus off until rd_data reflects the latched address.
   wire drive = (state == ACTIVE) & rd_valid & rd_s[1] & doe_s[1];
   assign zD = drive ? rd_data : 16'hzzzz;

   assign bus.zSLAVEN  = slave_n;
   assign bus.znCFGOUT = cfgout_n;

   wire unused_ok = &{1'b0, bus.zA[0], base[4:0]};
endmodule

// File: tb/tb_z2_autoconfig_ram.sv
// Directed bench for z2_autoconfig_ram; the pulled-up data bus reads 16'hFFFF when the card is off it.
module tb_z2_autoconfig_ram;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] tb_d;
   logic        tb_d_en;
   wire  [15:0] zD;
   int          checks = 0;
   int          failures = 0;

   z2_autoconfig_ram_if bus_if();

   z2_autoconfig_ram dut (
      .z_sample_clk(clk),
      .reset_n     (reset_n),
      .bus         (bus_if),
      .zD          (zD)
   );

   always #5 clk = ~clk;

   assign zD = tb_d_en ? tb_d : 16'hzzzz;
   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup (zD[i]);
   end

   task automatic bus_idle();
      bus_if.znAS  = 1'b1;
      bus_if.znUDS = 1'b1;
      bus_if.znLDS = 1'b1;
      bus_if.zDOE  = 1'b0;
      bus_if.zREAD = 1'b1;
      tb_d_en      = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus_idle();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic bus_read(input logic [23:0] addr, output logic [15:0] d, output logic sl);
      bus_if.zA    = addr;
      bus_if.zREAD = 1'b1;
      @(negedge clk);
      bus_if.znAS  = 1'b0;
      bus_if.znUDS = 1'b0;
      bus_if.znLDS = 1'b0;
      bus_if.zDOE  = 1'b1;
      repeat (8) @(negedge clk);
      d  = zD;
      sl = bus_if.zSLAVEN;
      bus_idle();
      repeat (5) @(negedge clk);
   endtask

   task automatic bus_write(input logic [23:0] addr, input logic [15:0] data,
                            input logic uds_n, input logic lds_n, output logic sl);
      bus_if.zA    = addr;
      bus_if.zREAD = 1'b0;
      tb_d         = data;
      tb_d_en      = 1'b1;
      @(negedge clk);
      bus_if.znAS  = 1'b0;
      bus_if.znUDS = uds_n;
      bus_if.znLDS = lds_n;
      repeat (8) @(negedge clk);
      sl = bus_if.zSLAVEN;
      bus_if.znAS  = 1'b1;
      bus_if.znUDS = 1'b1;
      bus_if.znLDS = 1'b1;
      @(negedge clk);
      bus_idle();
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus_if.znCFGOUT !== 1'b1) begin failures++; $display("FAIL reset_cfgout got=%b exp=1", bus_if.znCFGOUT); end
      checks++;
      if (bus_if.zSLAVEN !== 1'b1) begin failures++; $display("FAIL reset_slaven got=%b exp=1", bus_if.zSLAVEN); end
      checks++;
      if (zD !== 16'hFFFF) begin failures++; $display("FAIL reset_zd_released got=%h exp=ffff", zD); end
   endtask

   task automatic test_cfgin_and_midreset();
      logic [15:0] d;
      logic        sl;
      bus_if.znCFGIN = 1'b1;
      bus_read(24'hE80000, d, sl);
      checks++;
      if (sl !== 1'b1) begin failures++; $display("FAIL cfgin_high_slaven got=%b exp=1", sl); end
      checks++;
      if (d !== 16'hFFFF) begin failures++; $display("FAIL cfgin_high_zd got=%h exp=ffff", d); end
      bus_if.znCFGIN = 1'b0;
      bus_if.zA      = 24'hE80000;
      bus_if.zREAD   = 1'b1;
      @(negedge clk);
      bus_if.znAS  = 1'b0;
      bus_if.znUDS = 1'b0;
      bus_if.znLDS = 1'b0;
      bus_if.zDOE  = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (zD !== 16'hCFFF) begin failures++; $display("FAIL midreset_pre_zd got=%h exp=cfff", zD); end
      reset_n = 1'b0;
      #1;
      checks++;
      if (zD !== 16'hFFFF) begin failures++; $display("FAIL midreset_zd got=%h exp=ffff", zD); end
      checks++;
      if (bus_if.zSLAVEN !== 1'b1) begin failures++; $display("FAIL midreset_slaven got=%b exp=1", bus_if.zSLAVEN); end
      bus_idle();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      bus_read(24'hE80000, d, sl);
      checks++;
      if (d !== 16'hCFFF || sl !== 1'b0) begin
         failures++; $display("FAIL post_reset_read got=%h/%b exp=cfff/0", d, sl);
      end
   endtask

   task automatic test_cfg_read();
      logic [15:0] d;
      logic        sl;
      logic [23:0] addrs [8] = '{24'hE80000, 24'hE80002, 24'hE80004, 24'hE80006,
                                 24'hE80030, 24'hE80010, 24'hE80016, 24'hE80018};
      logic [15:0] exps  [8] = '{16'hCFFF, 16'h6FFF, 16'hFFFF, 16'hEFFF,
                                 16'hFFFF, 16'h9FFF, 16'h1FFF, 16'hFFFF};
      for (int i = 0; i < 8; i++) begin
         bus_read(addrs[i], d, sl);
         checks++;
         if (d !== exps[i] || sl !== 1'b0) begin
            failures++; $display("FAIL cfg_read_%h got=%h/%b exp=%h/0", addrs[i], d, sl, exps[i]);
         end
      end
      checks++;
      if (bus_if.znCFGOUT !== 1'b1) begin failures++; $display("FAIL cfgout_before_cfg got=%b exp=1", bus_if.znCFGOUT); end
   endtask

   task automatic test_cfg_write();
      logic [15:0] d;
      logic        sl;
      bus_write(24'hE8004C, 16'h2000, 1'b0, 1'b0, sl);
      checks++;
      if (bus_if.znCFGOUT !== 1'b1) begin failures++; $display("FAIL cfg_4c_ignored got=%b exp=1", bus_if.znCFGOUT); end
      bus_write(24'hE80048, 16'h6000, 1'b0, 1'b0, sl);
      checks++;
      if (sl !== 1'b0) begin failures++; $display("FAIL cfg_write_slaven got=%b exp=0", sl); end
      checks++;
      if (bus_if.znCFGOUT !== 1'b0) begin failures++; $display("FAIL cfg_write_cfgout got=%b exp=0", bus_if.znCFGOUT); end
      bus_read(24'hE80000, d, sl);
      checks++;
      if (d !== 16'hFFFF || sl !== 1'b1) begin
         failures++; $display("FAIL cfg_after_config got=%h/%b exp=ffff/1", d, sl);
      end
   endtask

   task automatic test_ram();
      logic [15:0] d;
      logic        sl;
      bus_write(24'h600000, 16'hBEEF, 1'b0, 1'b0, sl);
      checks++;
      if (sl !== 1'b0) begin failures++; $display("FAIL ram_write_slaven got=%b exp=0", sl); end
      bus_read(24'h600000, d, sl);
      checks++;
      if (d !== 16'hBEEF || sl !== 1'b0) begin failures++; $display("FAIL ram_word got=%h/%b exp=beef/0", d, sl); end
      bus_write(24'h600000, 16'h1234, 1'b1, 1'b0, sl);
      bus_read(24'h600000, d, sl);
      checks++;
      if (d !== 16'hBE34) begin failures++; $display("FAIL ram_lds_only got=%h exp=be34", d); end
      bus_write(24'h600000, 16'h5600, 1'b0, 1'b1, sl);
      bus_read(24'h600000, d, sl);
      checks++;
      if (d !== 16'h5634) begin failures++; $display("FAIL ram_uds_only got=%h exp=5634", d); end
      bus_write(24'h600000, 16'h0000, 1'b1, 1'b1, sl);
      bus_read(24'h600000, d, sl);
      checks++;
      if (d !== 16'h5634) begin failures++; $display("FAIL ram_no_strobe got=%h exp=5634", d); end
      bus_write(24'h7FFFFE, 16'hA5C3, 1'b0, 1'b0, sl);
      bus_read(24'h600800, d, sl);
      checks++;
      if (d !== 16'h5634 || sl !== 1'b0) begin failures++; $display("FAIL ram_alias got=%h/%b exp=5634/0", d, sl); end
      bus_read(24'h6007FE, d, sl);
      checks++;
      if (d !== 16'hA5C3) begin failures++; $display("FAIL ram_top_word got=%h exp=a5c3", d); end
      bus_read(24'h500000, d, sl);
      checks++;
      if (d !== 16'hFFFF || sl !== 1'b1) begin failures++; $display("FAIL ram_miss got=%h/%b exp=ffff/1", d, sl); end
   endtask

   initial begin
      bus_if.zA      = 24'h000000;
      bus_if.znCFGIN = 1'b0;
      tb_d           = 16'h0000;
      test_reset();
      test_cfgin_and_midreset();
      test_cfg_read();
      test_cfg_write();
      test_ram();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
